// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state encoding and default priority width for the interrupt arbiter
package irq_pkg;
  localparam int DefPrioWidth = 4;
  typedef enum logic {IDLE, PRESENT} state_e;
endpackage

// File: rtl/irq_prio_tree.sv
// irq_prio_tree: binary comparison tree picking the eligible line with max priority, lowest index on ties
//   elig_i  - per-line eligible flags
//   prio_i  - packed per-line priorities
//   valid_o - any line eligible
//   id_o    - winning line index
//   prio_o  - winning line priority
module irq_prio_tree
  import irq_pkg::*;
#(
  parameter int NrInputs  = 32,
  parameter int PrioWidth = DefPrioWidth,
  parameter int IdWidth   = $clog2(NrInputs)
) (
  input  logic [NrInputs-1:0]           elig_i,
  input  logic [NrInputs*PrioWidth-1:0] prio_i,
  output logic                          valid_o,
  output logic [IdWidth-1:0]            id_o,
  output logic [PrioWidth-1:0]          prio_o
);
  localparam int Leaves = 2 ** IdWidth;
  localparam int Nodes  = 2 * Leaves - 1;
  logic [Nodes-1:0]                v;
  logic [Nodes-1:0][PrioWidth-1:0] p;
  logic [Nodes-1:0][IdWidth-1:0]   d;
  // Heap layout: node k has children 2k+1 (lower indices) and 2k+2, so ">=" favours the lower index.
  always_comb begin
    v = '0;
    p = '0;
    d = '0;
    for (int i = 0; i < NrInputs; i++) begin
      v[Leaves-1+i] = elig_i[i];
      p[Leaves-1+i] = prio_i[i*PrioWidth +: PrioWidth];
      d[Leaves-1+i] = IdWidth'(i);
    end
    for (int k = Leaves - 2; k >= 0; k--) begin
      v[k] = v[2*k+1] | v[2*k+2];
      p[k] = (v[2*k+1] & (~v[2*k+2] | (p[2*k+1] >= p[2*k+2]))) ? p[2*k+1] : p[2*k+2];
      d[k] = (v[2*k+1] & (~v[2*k+2] | (p[2*k+1] >= p[2*k+2]))) ? d[2*k+1] : d[2*k+2];
    end
  end
  assign valid_o = v[0];
  assign id_o    = d[0];
  assign prio_o  = p[0];
endmodule

// File: rtl/irq_pending_arb.sv
// irq_pending_arb: pending register plus IDLE/PRESENT arbiter presenting the highest-priority enabled interrupt
//   clk_i, rst_i   - clock, async active-high reset
//   irqs_i         - one-cycle set pulses per line
//   ie_i, prio_i   - per-line enable and priority
//   threshold_i    - lines need priority strictly above this
//   ip_o           - pending vector
//   irq_valid_o/irq_id_o/irq_prio_o - registered presentation
//   irq_ready_i    - claim of the presented interrupt
module irq_pending_arb
  import irq_pkg::*;
#(
  parameter int NrInputs  = 32,
  parameter int PrioWidth = DefPrioWidth,
  localparam int IdWidth  = $clog2(NrInputs)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NrInputs-1:0]           irqs_i,
  input  logic [NrInputs-1:0]           ie_i,
  input  logic [NrInputs*PrioWidth-1:0] prio_i,
  input  logic [PrioWidth-1:0]          threshold_i,
  output logic [NrInputs-1:0]           ip_o,
  output logic                          irq_valid_o,
  output logic [IdWidth-1:0]            irq_id_o,
  output logic [PrioWidth-1:0]          irq_prio_o,
  input  logic                          irq_ready_i
);
  state_e                state_q;
  logic [NrInputs-1:0]   pend_q, pend_d, elig, clr;
  logic [IdWidth-1:0]    id_q, cand_id;
  logic [PrioWidth-1:0]  prio_q, cand_prio;
  logic                  cand_v, hs;
  always_comb begin
    elig = '0;
    for (int i = 0; i < NrInputs; i++)
      elig[i] = pend_q[i] & ie_i[i] & (prio_i[i*PrioWidth +: PrioWidth] > threshold_i);
  end
  irq_prio_tree #(.NrInputs(NrInputs), .PrioWidth(PrioWidth), .IdWidth(IdWidth)) u_tree (
    .elig_i (elig),
    .prio_i (prio_i),
    .valid_o(cand_v),
    .id_o   (cand_id),
    .prio_o (cand_prio)
  );
  assign hs     = (state_q == PRESENT) & irq_ready_i;
  assign clr    = hs ? (NrInputs'(1) << id_q) : '0;
  // Set wins over a same-cycle claim so a fresh pulse is never lost.
  assign pend_d = (pend_q & ~clr) | irqs_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      id_q    <= '0;
      prio_q  <= '0;
    end else begin
      pend_q <= pend_d;
      if (state_q == IDLE && cand_v) begin
        state_q <= PRESENT;
        id_q    <= cand_id;
        prio_q  <= cand_prio;
      end else if (hs) begin
        state_q <= IDLE;
      end
    end
  end
  assign ip_o        = pend_q;
  assign irq_valid_o = (state_q == PRESENT);
  assign irq_id_o    = id_q;
  assign irq_prio_o  = prio_q;
endmodule

// File: tb/tb_irq_pending_arb.sv
// tb_irq_pending_arb: scoreboard-driven checks of pending, arbitration, handshake and reset behaviour
module tb_irq_pending_arb;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  irqs_i = '0;
  logic [31:0]  ie_i = '1;
  logic [127:0] prio_i = '0;
  logic [3:0]   threshold_i = '0;
  logic [31:0]  ip_o;
  logic         irq_valid_o;
  logic [4:0]   irq_id_o;
  logic [3:0]   irq_prio_o;
  logic         irq_ready_i = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [41:0] sb[$];
  logic [41:0] e, got;

  irq_pending_arb dut (
    .clk_i(clk_i), .rst_i(rst_i), .irqs_i(irqs_i), .ie_i(ie_i), .prio_i(prio_i),
    .threshold_i(threshold_i), .ip_o(ip_o), .irq_valid_o(irq_valid_o),
    .irq_id_o(irq_id_o), .irq_prio_o(irq_prio_o), .irq_ready_i(irq_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [41:0] tup(logic v, logic [4:0] id, logic [3:0] pr, logic [31:0] ip);
    return {v, id, pr, ip};
  endfunction
  function automatic logic [31:0] b(int i);
    return 32'd1 << i;
  endfunction
  function automatic string fmt(logic [41:0] t);
    return $sformatf("v=%b id=%0d prio=%0d ip=%h", t[41], t[40:36], t[35:32], t[31:0]);
  endfunction
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic do_reset();
    rst_i = 1'b1; irqs_i = '0; ie_i = '1; prio_i = '0; threshold_i = '0; irq_ready_i = 1'b0;
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    sb.push_back(tup(0, 0, 0, 0));
    irqs_i = '1;
    prio_i = '1;
    step(); step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_held: got %s want %s", fmt(got), fmt(e)); end
    irqs_i = '0; prio_i = '0;
    rst_i = 1'b0;
    sb.push_back(tup(0, 0, 0, 0));
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_release: got %s want %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_single();
    do_reset();
    prio_i[5*4 +: 4] = 4'd3;
    irqs_i = b(5);
    sb.push_back(tup(0, 0, 0, b(5)));
    sb.push_back(tup(1, 5, 3, b(5)));
    sb.push_back(tup(0, 5, 3, 0));
    step(); irqs_i = '0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL single_n1: got %s want %s", fmt(got), fmt(e)); end
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL single_n2: got %s want %s", fmt(got), fmt(e)); end
    irq_ready_i = 1'b1;
    step(); irq_ready_i = 1'b0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL single_claim: got %s want %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_tie();
    do_reset();
    prio_i[2*4 +: 4] = 4'd7;
    prio_i[9*4 +: 4] = 4'd7;
    irqs_i = b(2) | b(9);
    sb.push_back(tup(0, 0, 0, b(2) | b(9)));
    sb.push_back(tup(1, 2, 7, b(2) | b(9)));
    step(); irqs_i = '0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL tie_pend: got %s want %s", fmt(got), fmt(e)); end
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL tie_first: got %s want %s", fmt(got), fmt(e)); end
    irq_ready_i = 1'b1;
    sb.push_back(tup(0, 2, 7, b(9)));
    step(); irq_ready_i = 1'b0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL tie_bubble: got %s want %s", fmt(got), fmt(e)); end
    sb.push_back(tup(1, 9, 7, b(9)));
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL tie_second: got %s want %s", fmt(got), fmt(e)); end
    irq_ready_i = 1'b1;
    sb.push_back(tup(0, 9, 7, 0));
    step(); irq_ready_i = 1'b0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL tie_done: got %s want %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_threshold_enable();
    do_reset();
    prio_i[4*4 +: 4] = 4'd2;
    threshold_i = 4'd2;
    irqs_i = b(4);
    sb.push_back(tup(0, 0, 0, b(4)));
    sb.push_back(tup(0, 0, 0, b(4)));
    step(); irqs_i = '0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL thr_pend: got %s want %s", fmt(got), fmt(e)); end
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL thr_equal: got %s want %s", fmt(got), fmt(e)); end
    threshold_i = 4'd1;
    ie_i[4] = 1'b0;
    sb.push_back(tup(0, 0, 0, b(4)));
    step(); step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL thr_disabled: got %s want %s", fmt(got), fmt(e)); end
    ie_i[4] = 1'b1;
    sb.push_back(tup(1, 4, 2, b(4)));
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL thr_enabled: got %s want %s", fmt(got), fmt(e)); end
    irq_ready_i = 1'b1;
    sb.push_back(tup(0, 4, 2, 0));
    step(); irq_ready_i = 1'b0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL thr_claim: got %s want %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_stable();
    do_reset();
    prio_i[3*4 +: 4] = 4'd2;
    prio_i[7*4 +: 4] = 4'd15;
    irqs_i = b(3);
    step(); irqs_i = '0;
    sb.push_back(tup(1, 3, 2, b(3)));
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL stable_first: got %s want %s", fmt(got), fmt(e)); end
    irqs_i = b(7);
    sb.push_back(tup(1, 3, 2, b(3) | b(7)));
    step(); irqs_i = '0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL stable_nopreempt: got %s want %s", fmt(got), fmt(e)); end
    threshold_i = 4'd5;
    prio_i[3*4 +: 4] = 4'd0;
    ie_i[3] = 1'b0;
    sb.push_back(tup(1, 3, 2, b(3) | b(7)));
    step(); step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL stable_hold: got %s want %s", fmt(got), fmt(e)); end
    irq_ready_i = 1'b1;
    sb.push_back(tup(0, 3, 2, b(7)));
    step(); irq_ready_i = 1'b0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL stable_bubble: got %s want %s", fmt(got), fmt(e)); end
    sb.push_back(tup(1, 7, 15, b(7)));
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL stable_next: got %s want %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_collide();
    do_reset();
    prio_i[6*4 +: 4] = 4'd4;
    irqs_i = b(6);
    step(); irqs_i = '0;
    sb.push_back(tup(1, 6, 4, b(6)));
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL collide_present: got %s want %s", fmt(got), fmt(e)); end
    irq_ready_i = 1'b1;
    irqs_i = b(6);
    sb.push_back(tup(0, 6, 4, b(6)));
    step(); irq_ready_i = 1'b0; irqs_i = '0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL collide_keep: got %s want %s", fmt(got), fmt(e)); end
    sb.push_back(tup(1, 6, 4, b(6)));
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL collide_again: got %s want %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_zero_prio();
    do_reset();
    irqs_i = b(1) | b(20);
    step(); irqs_i = '0;
    irq_ready_i = 1'b1;
    sb.push_back(tup(0, 0, 0, b(1) | b(20)));
    step(); step();
    irq_ready_i = 1'b0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL zero_prio: got %s want %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_collapse();
    do_reset();
    prio_i[31*4 +: 4] = 4'd1;
    irqs_i = b(31);
    step();
    sb.push_back(tup(1, 31, 1, b(31)));
    step(); irqs_i = '0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL collapse_present: got %s want %s", fmt(got), fmt(e)); end
    irq_ready_i = 1'b1;
    sb.push_back(tup(0, 31, 1, 0));
    step(); irq_ready_i = 1'b0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL collapse_claim: got %s want %s", fmt(got), fmt(e)); end
    sb.push_back(tup(0, 31, 1, 0));
    step(); step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL collapse_single: got %s want %s", fmt(got), fmt(e)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    prio_i[5*4 +: 4] = 4'd3;
    irqs_i = b(5);
    step(); irqs_i = '0;
    sb.push_back(tup(1, 5, 3, b(5)));
    step();
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL async_present: got %s want %s", fmt(got), fmt(e)); end
    #2 rst_i = 1'b1;
    sb.push_back(tup(0, 0, 0, 0));
    #1;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL async_clear: got %s want %s", fmt(got), fmt(e)); end
    rst_i = 1'b0;
    irq_ready_i = 1'b1;
    sb.push_back(tup(0, 0, 0, 0));
    step(); step();
    irq_ready_i = 1'b0;
    got = {irq_valid_o, irq_id_o, irq_prio_o, ip_o}; e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL async_lost: got %s want %s", fmt(got), fmt(e)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_threshold_enable();
    test_stable();
    test_collide();
    test_zero_prio();
    test_collapse();
    test_async_reset();
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/irq_pending_arb.md
IRQ_PENDING_ARB -- requirements
Module: irq_pending_arb

Interface
REQ-001 SHALL have parameter NrInputs, default 32, number of interrupt lines.
REQ-002 SHALL have parameter PrioWidth, default 4, width of each priority value.
REQ-003 SHALL derive IdWidth = $clog2(NrInputs).
REQ-004 SHALL have port clk_i, input, 1 bit: the only clock.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port irqs_i, input, NrInputs bits: one-cycle set pulses from the gateway stage.
REQ-007 SHALL have port ie_i, input, NrInputs bits: per-line enable.
REQ-008 SHALL have port prio_i, input, NrInputs*PrioWidth bits: line i priority in bits [i*PrioWidth +: PrioWidth].
REQ-009 SHALL have port threshold_i, input, PrioWidth bits: minimum priority to present, exclusive.
REQ-010 SHALL have port ip_o, output, NrInputs bits: pending vector, returned to the gateway ip_i.
REQ-011 SHALL have port irq_valid_o, output, 1 bit: a claimable interrupt is presented.
REQ-012 SHALL have port irq_id_o, output, IdWidth bits: presented line index.
REQ-013 SHALL have port irq_prio_o, output, PrioWidth bits: presented line priority.
REQ-014 SHALL have port irq_ready_i, input, 1 bit: core claims the presented interrupt.

Function
REQ-015 SHALL keep pending register pend_q; ip_o = pend_q.
REQ-016 SHALL set pend_q[i] in the cycle after irqs_i[i]=1, regardless of ie_i.
REQ-017 SHALL clear pend_q[irq_id_o] in the cycle after a handshake (irq_valid_o & irq_ready_i).
REQ-018 SHALL, when a set pulse and a claim-clear hit the same line in the same cycle, give priority to the set, so the line stays pending.
REQ-019 SHALL define a line as eligible when pend_q[i] & ie_i[i] & (prio > threshold_i).
REQ-020 SHALL choose the candidate as the eligible line with maximum priority; ties go to the lowest index.
REQ-021 SHALL implement an FSM with states IDLE and PRESENT.
REQ-022 SHALL, in IDLE, register the candidate id/prio into irq_id_o/irq_prio_o and go to PRESENT if any line is eligible; otherwise stay in IDLE.
REQ-023 SHALL drive irq_valid_o=1 exactly when in PRESENT.
REQ-024 SHALL hold irq_id_o/irq_prio_o stable in PRESENT until the handshake, with no preemption, even if ie_i, prio_i or threshold_i change.
REQ-025 SHALL, in PRESENT with irq_ready_i=1, clear the pending bit and return to IDLE, leaving one bubble cycle before the next presentation.
REQ-026 SHALL ignore irq_ready_i while in IDLE.
REQ-027 SHALL have latency: irqs_i pulse in cycle N -> ip_o in N+1 -> irq_valid_o in N+2, if eligible and the FSM is in IDLE.
REQ-028 SHALL give each line a single pending bit, so repeated pulses while pending collapse into one.
REQ-029 SHALL, with all priorities 0 and threshold 0, present nothing.

Reset
REQ-030 SHALL, on rst_i, immediately clear pend_q=0, set state=IDLE, irq_valid_o=0, irq_id_o=0 and irq_prio_o=0.
REQ-031 SHALL, on reset in the middle of PRESENT, drop the presentation and lose the pending state; no claim completes.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, PRESENT) and the default PrioWidth constant in shared package irq_pkg.
REQ-033 SHALL put max-priority/lowest-index selection in combinational sub-module irq_prio_tree, a binary comparison tree parameterised by NrInputs and PrioWidth.
REQ-034 SHALL register all outputs; the only combinational path is irq_ready_i into the next state.

Verification
REQ-035 SHALL test single pulse: irqs_i[5] pulse, ie=all ones, prio[5]=3, threshold=0 -> ip_o[5]=1 at N+1; valid=1, id=5, prio=3 at N+2.
REQ-036 SHALL test tie-break: lines 2 and 9 both prio 7 -> id=2 presented first; after claim plus bubble, id=9.
REQ-037 SHALL test threshold and enable: prio[4]=2, threshold=2 -> no valid; with threshold=1 and ie[4]=0 -> no valid; with ie[4]=1 -> valid, id=4.
REQ-038 SHALL test stability: presenting id=3 prio 2, ready held 0, line 7 pulses with prio 15 -> id stays 3 until claim, then id=7 two cycles after the handshake.
REQ-039 SHALL test set/clear collision: handshake on id=6 while irqs_i[6]=1 in the same cycle -> ip_o[6] stays 1 and id=6 is re-presented after the bubble.
REQ-040 SHALL test async reset: assert rst_i in PRESENT, off-edge -> valid, ip_o and id go to 0 without a clock edge.
